// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: access size codes
// and the debug-dump state machine states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DUMP = 2'b01,
    ST_DONE = 2'b10
  } dump_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_lsu: alignment check, load extraction with
// sign/zero extension, and store data/byte-mask placement within a word.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int OFF_W      = (DATA_WIDTH == 64) ? 3 : 2,
  localparam int NBYTES     = DATA_WIDTH / 8
) (
  input  logic [1:0]            size_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  logic                  isUnsigned_i,
  input  logic [DATA_WIDTH-1:0] rdWord_i,
  input  logic [DATA_WIDTH-1:0] wrData_i,
  output logic                  misaligned_o,
  output logic [DATA_WIDTH-1:0] loadData_o,
  output logic [DATA_WIDTH-1:0] wrLanes_o,
  output logic [NBYTES-1:0]     byteMask_o
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [NBYTES-1:0]     sizeMask;
  logic                  signBit;
  int                    nBytes;

  // A 64-bit access can never be satisfied by a 32-bit wide memory.
  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: misaligned_o = 1'b0;
      SZ_HALF: misaligned_o = offset_i[0];
      SZ_WORD: misaligned_o = |offset_i[1:0];
      default: misaligned_o = (DATA_WIDTH != 64) || (|offset_i);
    endcase
  end

  always_comb begin
    shifted    = rdWord_i >> {offset_i, 3'b000};
    nBytes     = NBYTES;
    signBit    = 1'b0;
    loadData_o = '0;
    sizeMask   = '0;
    case (size_i)
      SZ_BYTE: begin nBytes = 1; signBit = ~isUnsigned_i & shifted[7];  end
      SZ_HALF: begin nBytes = 2; signBit = ~isUnsigned_i & shifted[15]; end
      SZ_WORD: begin nBytes = 4; signBit = ~isUnsigned_i & shifted[31]; end
      default: begin nBytes = NBYTES; signBit = shifted[DATA_WIDTH-1]; end
    endcase
    for (int b = 0; b < DATA_WIDTH; b++) begin
      loadData_o[b] = (b < 8 * nBytes) ? shifted[b] : signBit;
    end
    for (int b = 0; b < NBYTES; b++) begin
      sizeMask[b] = (b < nBytes);
    end
    wrLanes_o  = wrData_i << {offset_i, 3'b000};
    byteMask_o = sizeMask << offset_i;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed little-endian data memory with load/store unit and an
// optional debug memory dump port, enabled by defining DMEM_LSU_DEBUG_DUMP_EN.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic                     i_read_enable,
  input  logic                     i_write_enable,
  input  logic [1:0]               i_size,
  input  logic                     i_unsigned,
  input  logic [ADDR_WIDTH-1:0]    i_address,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic                     o_read_valid,
  output logic                     o_misaligned,
  input  logic                     i_dbg_start,
  input  logic                     i_dbg_ready,
  output logic                     o_dbg_valid,
  output logic [$clog2(DEPTH)-1:0] o_dbg_addr,
  output logic [DATA_WIDTH-1:0]    o_dbg_data,
  output logic                     o_dbg_done
);

  localparam int OFF_W  = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};

  logic [IDX_W-1:0]      wordIdx;
  logic [OFF_W-1:0]      byteOff;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] wrLanes;
  logic [NBYTES-1:0]     byteMask;
  logic                  isAccess;
  logic                  doWrite;
  logic                  doRead;
  logic                  unusedAddr;

  logic [DATA_WIDTH-1:0] readData_q;
  logic                  readValid_q;
  logic                  misaligned_q;

  // Address bits above the word index are ignored so accesses wrap modulo DEPTH.
  assign wordIdx    = i_address[OFF_W +: IDX_W];
  assign byteOff    = i_address[OFF_W-1:0];
  assign unusedAddr = ^i_address;

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .size_i       (i_size),
    .offset_i     (byteOff),
    .isUnsigned_i (i_unsigned),
    .rdWord_i     (mem_q[wordIdx]),
    .wrData_i     (i_write_data),
    .misaligned_o (misaligned),
    .loadData_o   (loadData),
    .wrLanes_o    (wrLanes),
    .byteMask_o   (byteMask)
  );

  assign isAccess = i_valid & (i_read_enable | i_write_enable);
  assign doWrite  = i_valid & i_write_enable & ~misaligned;
  assign doRead   = i_valid & i_read_enable & ~i_write_enable & ~misaligned;

  // Memory has no reset so contents survive i_reset.
  always_ff @(posedge i_clk) begin
    if (doWrite) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (byteMask[b]) begin
          mem_q[wordIdx][8*b +: 8] <= wrLanes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      readData_q   <= '0;
      readValid_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      readValid_q  <= doRead;
      misaligned_q <= isAccess & misaligned;
      if (doRead) begin
        readData_q <= loadData;
      end
    end
  end

  assign o_read_data  = readData_q;
  assign o_read_valid = readValid_q;
  assign o_misaligned = misaligned_q;

`ifdef DMEM_LSU_DEBUG_DUMP_EN
  dump_state_e           state_q, state_d;
  logic [IDX_W-1:0]      dbgIdx_q, dbgIdx_d;
  logic [DATA_WIDTH-1:0] dbgData_q, dbgData_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      dbgIdx_q  <= '0;
      dbgData_q <= '0;
    end else begin
      state_q   <= state_d;
      dbgIdx_q  <= dbgIdx_d;
      dbgData_q <= dbgData_d;
    end
  end

  // The beat is captured into dbgData_q so later stores cannot disturb it.
  always_comb begin
    state_d     = state_q;
    dbgIdx_d    = dbgIdx_q;
    dbgData_d   = dbgData_q;
    o_dbg_valid = 1'b0;
    o_dbg_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_dbg_start) begin
          state_d   = ST_DUMP;
          dbgIdx_d  = '0;
          dbgData_d = mem_q[0];
        end
      end
      ST_DUMP: begin
        o_dbg_valid = 1'b1;
        if (i_dbg_ready) begin
          if (dbgIdx_q == IDX_W'(DEPTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            dbgIdx_d  = dbgIdx_q + 1'b1;
            dbgData_d = mem_q[dbgIdx_d];
          end
        end
      end
      ST_DONE: begin
        o_dbg_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_dbg_addr = dbgIdx_q;
  assign o_dbg_data = dbgData_q;
`else
  logic unusedDbg;

  assign unusedDbg   = i_dbg_start ^ i_dbg_ready;
  assign o_dbg_valid = 1'b0;
  assign o_dbg_addr  = '0;
  assign o_dbg_data  = '0;
  assign o_dbg_done  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu (32-bit, DEPTH=8): directed vectors, random
// traffic against a byte-level memory model, debug-dump and reset sequences.
`timescale 1ns/1ps
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int          DEPTH     = 8;
  localparam int          MEM_BYTES = DEPTH * 4;
  localparam logic [31:0] INIT      = 32'h5A5A_C3C3;
  localparam int          NVEC      = 19;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0, readEn = 1'b0, writeEn = 1'b0, isUnsigned = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData, dbgData;
  logic        readValid, misaligned, dbgValid, dbgDone;
  logic        dbgStart = 1'b0, dbgReady = 1'b0;
  logic [2:0]  dbgAddr;

  dmem_lsu #(
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32),
    .INIT_VALUE (INIT)
  ) dut (
    .i_clk          (clock),
    .i_reset        (reset),
    .i_valid        (valid),
    .i_read_enable  (readEn),
    .i_write_enable (writeEn),
    .i_size         (size),
    .i_unsigned     (isUnsigned),
    .i_address      (address),
    .i_write_data   (writeData),
    .o_read_data    (readData),
    .o_read_valid   (readValid),
    .o_misaligned   (misaligned),
    .i_dbg_start    (dbgStart),
    .i_dbg_ready    (dbgReady),
    .o_dbg_valid    (dbgValid),
    .o_dbg_addr     (dbgAddr),
    .o_dbg_data     (dbgData),
    .o_dbg_done     (dbgDone)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v, re, we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wdata;
    logic        eValid, eMis;
    logic [31:0] eData;
  } vec_t;

  vec_t        vecs [NVEC];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  refMem [MEM_BYTES];
  logic [31:0] expData = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelWord(input int idx);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w |= 32'(refMem[(4 * idx + i) % MEM_BYTES]) << (8 * i);
    return w;
  endfunction

  // Memory is a flat byte array; an access of n bytes must sit on a multiple of n.
  task automatic modelStep(input logic v, re, we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, wdata, output logic expValid, expMis);
    int n = 1 << sz;
    int base = int'(addr % MEM_BYTES);
    logic [63:0] val = '0;
    expValid = 1'b0;
    expMis   = 1'b0;
    if (!(v && (re || we))) return;
    if (n > 4 || (addr % n) != 0) begin
      expMis = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < n; i++) refMem[(base + i) % MEM_BYTES] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) val |= 64'(refMem[(base + i) % MEM_BYTES]) << (8 * i);
      if (!uns && n < 4 && val[8*n-1]) val = val - (64'd1 << (8 * n));
      expData  = val[31:0];
      expValid = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic v, re, we, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, wdata);
    valid = v; readEn = re; writeEn = we; size = sz; isUnsigned = uns;
    address = addr; writeData = wdata;
    @(posedge clock);
    #1;
  endtask

  task automatic accessAndCheck(input string name, input logic v, re, we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, wdata);
    logic ev, em;
    modelStep(v, re, we, sz, uns, addr, wdata, ev, em);
    applyStimulus(v, re, we, sz, uns, addr, wdata);
    checkOutput({name, "_valid"}, 64'(readValid), 64'(ev));
    checkOutput({name, "_mis"}, 64'(misaligned), 64'(em));
    checkOutput({name, "_data"}, 64'(readData), 64'(expData));
  endtask

  task automatic cpuIdle();
    valid = 1'b0; readEn = 1'b0; writeEn = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] initWord;
    logic [31:0] oldWord, newWord, prevData;
    logic [2:0]  prevAddr;
    logic        mv, mm, stalled;
    int          beats, doneCount;

    initWord = INIT;
    for (int i = 0; i < MEM_BYTES; i++) refMem[i] = initWord[8*(i%4) +: 8];

    vecs[0]  = '{1'b1, 1'b0, 1'b1, SZ_WORD,  1'b0, 32'h10, 32'h80FF1234, 1'b0, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, SZ_BYTE,  1'b0, 32'h13, 32'h0,        1'b1, 1'b0, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, SZ_HALF,  1'b1, 32'h10, 32'h0,        1'b1, 1'b0, 32'h00001234};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, SZ_HALF,  1'b0, 32'h12, 32'h0,        1'b1, 1'b0, 32'hFFFF80FF};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, SZ_BYTE,  1'b0, 32'h11, 32'h000000AB, 1'b0, 1'b0, 32'hFFFF80FF};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, SZ_WORD,  1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h80FFAB34};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, SZ_WORD,  1'b0, 32'h06, 32'h0,        1'b0, 1'b1, 32'h80FFAB34};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, SZ_WORD,  1'b0, 32'h06, 32'hDEADBEEF, 1'b0, 1'b1, 32'h80FFAB34};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, SZ_WORD,  1'b0, 32'h04, 32'h0,        1'b1, 1'b0, 32'h5A5AC3C3};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, SZ_BYTE,  1'b1, 32'h13, 32'h0,        1'b1, 1'b0, 32'h00000080};
    vecs[10] = '{1'b1, 1'b1, 1'b0, SZ_DWORD, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 32'h00000080};
    vecs[11] = '{1'b1, 1'b1, 1'b0, SZ_HALF,  1'b0, 32'h11, 32'h0,        1'b0, 1'b1, 32'h00000080};
    vecs[12] = '{1'b1, 1'b1, 1'b1, SZ_WORD,  1'b0, 32'h18, 32'h11223344, 1'b0, 1'b0, 32'h00000080};
    vecs[13] = '{1'b1, 1'b1, 1'b0, SZ_WORD,  1'b0, 32'h38, 32'h0,        1'b1, 1'b0, 32'h11223344};
    vecs[14] = '{1'b1, 1'b1, 1'b0, SZ_HALF,  1'b0, 32'h1A, 32'h0,        1'b1, 1'b0, 32'h00001122};
    vecs[15] = '{1'b1, 1'b1, 1'b0, SZ_BYTE,  1'b0, 32'h1B, 32'h0,        1'b1, 1'b0, 32'h00000011};
    vecs[16] = '{1'b1, 1'b1, 1'b0, SZ_HALF,  1'b1, 32'h12, 32'h0,        1'b1, 1'b0, 32'h000080FF};
    vecs[17] = '{1'b1, 1'b1, 1'b0, SZ_WORD,  1'b1, 32'h10, 32'h0,        1'b1, 1'b0, 32'h80FFAB34};
    vecs[18] = '{1'b0, 1'b1, 1'b0, SZ_WORD,  1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h80FFAB34};

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_read_data", 64'(readData), 64'h0);
    checkOutput("rst_read_valid", 64'(readValid), 64'h0);
    checkOutput("rst_misaligned", 64'(misaligned), 64'h0);
    checkOutput("rst_dbg_valid", 64'(dbgValid), 64'h0);
    checkOutput("rst_dbg_done", 64'(dbgDone), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      modelStep(vecs[i].v, vecs[i].re, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, mv, mm);
      applyStimulus(vecs[i].v, vecs[i].re, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_valid", i), 64'(readValid), 64'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d_mis", i), 64'(misaligned), 64'(vecs[i].eMis));
      checkOutput($sformatf("vec%0d_data", i), 64'(readData), 64'(vecs[i].eData));
    end

    for (int t = 0; t < 300; t++) begin
      accessAndCheck($sformatf("rand%0d", t), ($urandom_range(9) != 0), 1'($urandom_range(1)),
                     ($urandom_range(3) == 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
                     32'($urandom_range(127)), $urandom);
    end
    cpuIdle();

`ifdef DMEM_LSU_DEBUG_DUMP_EN
    dbgReady = 1'b0;
    dbgStart = 1'b1;
    tick();
    dbgStart = 1'b0;
    beats = 0; doneCount = 0; stalled = 1'b0; prevAddr = '0; prevData = '0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (dbgValid && stalled) begin
        checkOutput("dump_stable_addr", 64'(dbgAddr), 64'(prevAddr));
        checkOutput("dump_stable_data", 64'(dbgData), 64'(prevData));
      end
      dbgReady = cyc[0];
      if (dbgValid && dbgReady) begin
        checkOutput($sformatf("dump_beat%0d_addr", beats), 64'(dbgAddr), 64'(beats % DEPTH));
        checkOutput($sformatf("dump_beat%0d_data", beats), 64'(dbgData), 64'(modelWord(beats % DEPTH)));
        beats++;
      end
      stalled  = dbgValid && !dbgReady;
      prevAddr = dbgAddr;
      prevData = dbgData;
      if (dbgDone) doneCount++;
      tick();
    end
    checkOutput("dump_beats", 64'(beats), 64'd8);
    checkOutput("dump_done_pulses", 64'(doneCount), 64'd1);

    dbgReady = 1'b0;
    dbgStart = 1'b1;
    tick();
    dbgStart = 1'b0;
    oldWord = modelWord(0);
    newWord = oldWord ^ 32'hFFFF_0001;
    checkOutput("dump2_first_valid", 64'(dbgValid), 64'd1);
    checkOutput("dump2_first_data", 64'(dbgData), 64'(oldWord));
    accessAndCheck("dump_store", 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0, newWord);
    accessAndCheck("dump_load", 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    cpuIdle();
    checkOutput("dump_held_addr", 64'(dbgAddr), 64'd0);
    checkOutput("dump_held_data", 64'(dbgData), 64'(oldWord));

    dbgReady = 1'b1;
    for (int k = 0; k < 8 && dbgAddr != 3'd2; k++) tick();
    checkOutput("dump2_reach_idx2", 64'(dbgAddr), 64'd2);
    dbgReady = 1'b0;
    dbgStart = 1'b1;
    tick();
    dbgStart = 1'b0;
    checkOutput("start_ignored_addr", 64'(dbgAddr), 64'd2);
    checkOutput("start_ignored_valid", 64'(dbgValid), 64'd1);
    dbgReady = 1'b1;
    tick();
    dbgReady = 1'b0;
    checkOutput("dump2_idx3_addr", 64'(dbgAddr), 64'd3);
    checkOutput("dump2_idx3_data", 64'(dbgData), 64'(modelWord(3)));
`else
    dbgStart = 1'b1;
    dbgReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      dbgStart = 1'b0;
      checkOutput("nodbg_valid", 64'(dbgValid), 64'h0);
      checkOutput("nodbg_done", 64'(dbgDone), 64'h0);
      checkOutput("nodbg_addr", 64'(dbgAddr), 64'h0);
      checkOutput("nodbg_data", 64'(dbgData), 64'h0);
    end
    accessAndCheck("pre_rst_store", 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h14, 32'h13579BDF);
    accessAndCheck("pre_rst_load", 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
    cpuIdle();
`endif

    reset = 1'b1;
    #1;
    checkOutput("midrst_read_data", 64'(readData), 64'h0);
    checkOutput("midrst_read_valid", 64'(readValid), 64'h0);
    checkOutput("midrst_misaligned", 64'(misaligned), 64'h0);
    checkOutput("midrst_dbg_valid", 64'(dbgValid), 64'h0);
    checkOutput("midrst_dbg_addr", 64'(dbgAddr), 64'h0);
    checkOutput("midrst_dbg_data", 64'(dbgData), 64'h0);
    checkOutput("midrst_dbg_done", 64'(dbgDone), 64'h0);
    tick();
    reset = 1'b0;
    expData = '0;
    dbgReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("post_rst_idle_valid", 64'(dbgValid), 64'h0);
      checkOutput("post_rst_idle_done", 64'(dbgDone), 64'h0);
    end
    accessAndCheck("post_rst_lw0", 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    accessAndCheck("post_rst_lw3", 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0);
    accessAndCheck("post_rst_lw5", 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
    cpuIdle();
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
